// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one structural full-adder cell time-shared over WIDTH cycles, LSB first.
// Optional signed-overflow output Ovf is built when SERIAL_ADDER_OVF_EN is defined.

module half_adder (
  input  logic i_a,
  input  logic i_b,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b;
  assign o_c = i_a & i_b;
endmodule

module full_adder_using_half_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);
  logic w_s1, w_c1, w_c2;

  half_adder u_ha0 (.i_a(i_a),  .i_b(i_b),   .o_s(w_s1),  .o_c(w_c1));
  half_adder u_ha1 (.i_a(w_s1), .i_b(i_cin), .o_s(o_sum), .o_c(w_c2));

  assign o_cout = w_c1 | w_c2;
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             done,
  output logic             Ovf
`else
  output logic             done
`endif
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr, r_sum;
  logic [CW-1:0]    r_bit_cnt;
  logic             r_carry, r_cout, r_busy, r_done;
  logic             w_fa_sum, w_fa_cout, w_last;

  full_adder_using_half_adder u_fa (
    .i_a   (r_a_sr[0]),
    .i_b   (r_b_sr[0]),
    .i_cin (r_carry),
    .o_sum (w_fa_sum),
    .o_cout(w_fa_cout)
  );

  assign w_last = (r_bit_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;

  // Carry into the MSB is the carry register while the MSB is being added.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          r_ovf <= 1'b0;
    else if (r_state == S_RUN && w_last) r_ovf <= r_carry ^ w_fa_cout;
  end

  assign Ovf = r_ovf;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr    <= '0;
      r_b_sr    <= '0;
      r_sum_sr  <= '0;
      r_sum     <= '0;
      r_bit_cnt <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: if (start) begin
          r_a_sr    <= A;
          r_b_sr    <= B;
          r_carry   <= Cin;
          r_bit_cnt <= '0;
        end
        S_RUN: begin
          r_sum_sr  <= {w_fa_sum, r_sum_sr[WIDTH-1:1]};
          r_carry   <= w_fa_cout;
          r_a_sr    <= {1'b0, r_a_sr[WIDTH-1:1]};
          r_b_sr    <= {1'b0, r_b_sr[WIDTH-1:1]};
          r_bit_cnt <= r_bit_cnt + CW'(1);
          if (w_last) begin
            r_sum  <= {w_fa_sum, r_sum_sr[WIDTH-1:1]};
            r_cout <= w_fa_cout;
            r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign Sum  = r_sum;
  assign Cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;
endmodule
